// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC replay path.
// Sample words carry channel B in the upper half, channel A in the lower half.
package adc_pkg;

    localparam int DATA_W = 16;
    localparam int SAMPLE_W = 16;
    localparam int WORD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PLAY,
        UNDER
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] chb;
        logic [DATA_W-1:0] cha;
    } word_t;

endpackage

// File: rtl/adc_replay_fifo.sv
// Synchronous sample FIFO with occupancy level and registered read port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module adc_replay_fifo #(
    parameter int DEPTH = 4096,
    parameter int W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wdata,
    input  logic                     rd_en,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
        end else begin
            if (wr_en) wptr <= wptr + ONE;
            if (rd_en) begin
                rptr  <= rptr + ONE;
                rdata <= mem[rptr[AW-1:0]];
            end
        end
    end

    assign level = wptr - rptr;
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

endmodule

// File: rtl/adc_replay.sv
// Replays sop/eop-framed sample packets as ADC samples timed by the radar strobes.
// Input framing is checked independently of the replay FSM.
module adc_replay
    import adc_pkg::*;
#(
    parameter int DEPTH = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                CPIB,
    input  logic                CPIE,
    input  logic                sample_gate,
    input  logic [SAMPLE_W-1:0] sample_num,
    input  logic [15:0]         chirp_num,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_valid,
    input  logic                s_sop,
    input  logic                s_eop,
    output logic                s_ready,
    output logic [DATA_W-1:0]   adc_data_cha,
    output logic [DATA_W-1:0]   adc_data_chb,
    output logic                adc_data_valid,
    output logic [31:0]         frame_err_cnt,
    output logic [31:0]         underrun_cnt,
    output logic [15:0]         chirp_cnt,
    output logic                err_irp
);

    localparam int LW = $clog2(DEPTH) + 1;

    state_e state;
    state_e state_nx;

    logic [SAMPLE_W-1:0] sample_num_l;
    logic [15:0]         chirp_num_l;
    logic [SAMPLE_W-1:0] cnt;
    logic [SAMPLE_W-1:0] wcnt;
    logic [SAMPLE_W-1:0] wnext;

    logic [WORD_W-1:0] rdata;
    word_t             rd_w;
    logic [LW-1:0]     level;
    logic              full;
    logic              empty;
    logic              wr_en;
    logic              rd_en;

    logic acc;
    logic in_frame;
    logic orphan;
    logic frame_err;

    logic gate_d;
    logic rise;
    logic level_ok;
    logic go;
    logic last;
    logic slot;
    logic pop;
    logic zero;
    logic fin;
    logic under_evt;
    logic s1_vld;
    logic s1_zero;

    adc_replay_fifo #(
        .DEPTH(DEPTH),
        .W    (WORD_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .wr_en(wr_en),
        .wdata(s_data),
        .rd_en(rd_en),
        .rdata(rdata),
        .level(level),
        .full (full),
        .empty(empty)
    );

    assign s_ready = !rst && !full;
    assign acc     = s_valid && s_ready;
    assign wnext   = wcnt + 16'd1;

    // Orphan words are dropped; every other erroring word still lands in the FIFO.
    always_comb begin
        wr_en     = 1'b0;
        frame_err = 1'b0;
        if (acc) begin
            if (s_sop) begin
                wr_en     = 1'b1;
                frame_err = in_frame || (s_eop && sample_num_l != 16'd1);
            end else if (in_frame) begin
                wr_en     = 1'b1;
                frame_err = s_eop && (wnext != sample_num_l);
            end else begin
                frame_err = !orphan;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame <= 1'b0;
            orphan   <= 1'b0;
            wcnt     <= '0;
        end else if (acc) begin
            if (s_sop) begin
                wcnt     <= 16'd1;
                in_frame <= !s_eop;
                orphan   <= 1'b0;
            end else if (in_frame) begin
                wcnt <= wnext;
                if (s_eop) in_frame <= 1'b0;
            end else begin
                orphan <= 1'b1;
            end
        end
    end

    assign rise     = sample_gate && !gate_d;
    assign level_ok = 32'(level) >= 32'(sample_num_l);
    assign go       = (state == ARMED) && rise
                      && (sample_num_l != '0)
                      && (chirp_cnt < chirp_num_l);
    assign last     = (cnt == sample_num_l - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = IDLE;
            ARMED: begin
                if (go && sample_num_l != 16'd1)
                    state_nx = level_ok ? PLAY : UNDER;
            end
            PLAY:  if (last) state_nx = ARMED;
            UNDER: if (last) state_nx = ARMED;
        endcase
        if (CPIE) state_nx = IDLE;
        if (CPIB) state_nx = ARMED;
    end

    // First slot of a chirp is taken in the rising-edge cycle itself.
    always_comb begin
        slot      = 1'b0;
        pop       = 1'b0;
        zero      = 1'b0;
        fin       = 1'b0;
        under_evt = 1'b0;
        unique case (state)
            IDLE: ;
            ARMED: begin
                slot      = go;
                pop       = go && level_ok;
                zero      = go && !level_ok;
                under_evt = go && !level_ok;
                fin       = go && sample_num_l == 16'd1;
            end
            PLAY: begin
                slot = 1'b1;
                pop  = 1'b1;
                fin  = last;
            end
            UNDER: begin
                slot = 1'b1;
                zero = 1'b1;
                fin  = last;
            end
        endcase
    end

    assign rd_en = pop && !empty;
    assign rd_w  = rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_d       <= 1'b0;
            cnt          <= '0;
            sample_num_l <= '0;
            chirp_num_l  <= '0;
            chirp_cnt    <= '0;
        end else begin
            gate_d <= sample_gate;
            if (go)
                cnt <= 16'd1;
            else if (state == PLAY || state == UNDER)
                cnt <= cnt + 16'd1;
            if (CPIB) begin
                sample_num_l <= sample_num;
                chirp_num_l  <= chirp_num;
                chirp_cnt    <= '0;
            end else if (fin) begin
                chirp_cnt <= chirp_cnt + 16'd1;
            end
        end
    end

    // Slots after an early gate fall still pop, but never reach the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld         <= 1'b0;
            s1_zero        <= 1'b0;
            adc_data_valid <= 1'b0;
            adc_data_cha   <= '0;
            adc_data_chb   <= '0;
        end else begin
            s1_vld         <= slot && sample_gate;
            s1_zero        <= zero;
            adc_data_valid <= s1_vld;
            if (s1_vld && !s1_zero) begin
                adc_data_cha <= rd_w.cha;
                adc_data_chb <= rd_w.chb;
            end else begin
                adc_data_cha <= '0;
                adc_data_chb <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_cnt <= '0;
            underrun_cnt  <= '0;
            err_irp       <= 1'b0;
        end else begin
            if (frame_err) frame_err_cnt <= frame_err_cnt + 32'd1;
            if (under_evt) underrun_cnt <= underrun_cnt + 32'd1;
            err_irp <= frame_err || under_evt;
        end
    end

endmodule

// File: tb/tb_adc_replay.sv
// Directed self-checking bench for adc_replay.
// Uses a 16-word FIFO so the full/ready boundary is reached quickly.
module tb_adc_replay;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CPIB = 1'b0;
    logic        CPIE = 1'b0;
    logic        sample_gate = 1'b0;
    logic [15:0] sample_num = '0;
    logic [15:0] chirp_num = '0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_sop = 1'b0;
    logic        s_eop = 1'b0;
    logic        s_ready;
    logic [15:0] adc_data_cha;
    logic [15:0] adc_data_chb;
    logic        adc_data_valid;
    logic [31:0] frame_err_cnt;
    logic [31:0] underrun_cnt;
    logic [15:0] chirp_cnt;
    logic        err_irp;

    int checks = 0;
    int failures = 0;
    int irp_total = 0;
    logic [31:0] q [$];

    adc_replay #(.DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .CPIB          (CPIB),
        .CPIE          (CPIE),
        .sample_gate   (sample_gate),
        .sample_num    (sample_num),
        .chirp_num     (chirp_num),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_sop         (s_sop),
        .s_eop         (s_eop),
        .s_ready       (s_ready),
        .adc_data_cha  (adc_data_cha),
        .adc_data_chb  (adc_data_chb),
        .adc_data_valid(adc_data_valid),
        .frame_err_cnt (frame_err_cnt),
        .underrun_cnt  (underrun_cnt),
        .chirp_cnt     (chirp_cnt),
        .err_irp       (err_irp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (adc_data_valid) q.push_back({adc_data_chb, adc_data_cha});
        if (err_irp) irp_total++;
    end

    function automatic logic [31:0] w(input int i);
        logic [15:0] a;
        a = 16'(i);
        return {a + 16'h1000, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic cpib(input int n, input int c);
        sample_num = 16'(n);
        chirp_num  = 16'(c);
        CPIB = 1'b1;
        @(negedge clk);
        CPIB = 1'b0;
    endtask

    task automatic put(input logic [31:0] d, input logic sop, input logic eop);
        int guard = 0;
        s_data = d;
        s_sop = sop;
        s_eop = eop;
        s_valid = 1'b1;
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("put_timeout", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_sop = 1'b0;
        s_eop = 1'b0;
    endtask

    task automatic send_pkt(input int first, input int len);
        for (int i = 0; i < len; i++)
            put(w(first + i), i == 0, i == len - 1);
        @(negedge clk);
    endtask

    task automatic gate_run(input int n);
        sample_gate = 1'b1;
        repeat (n) @(negedge clk);
        sample_gate = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic chk_seq(input string tag, input int base, input int first, input int n);
        chk({tag, "_count"}, 32'(q.size() - base), 32'(n));
        for (int i = 0; i < n; i++)
            chk(tag, q[base + i], (first == 0) ? 32'd0 : w(first + i));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ib;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_valid", {31'd0, adc_data_valid}, 32'd0);
        chk("rst_data", {adc_data_chb, adc_data_cha}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, s_ready}, 32'd1);
        chk("post_rst_ferr", frame_err_cnt, 32'd0);
        chk("post_rst_chirp", {16'd0, chirp_cnt}, 32'd0);

        // two full chirps in order, fixed latency, saturation
        cpib(8, 2);
        send_pkt(1, 8);
        send_pkt(9, 8);
        chk("t1_ferr", frame_err_cnt, 32'd0);
        base = q.size();
        sample_gate = 1'b1;
        @(negedge clk);
        chk("t1_lat_v0", {31'd0, adc_data_valid}, 32'd0);
        @(negedge clk);
        chk("t1_lat_v1", {31'd0, adc_data_valid}, 32'd1);
        chk("t1_lat_d", {adc_data_chb, adc_data_cha}, w(1));
        repeat (6) @(negedge clk);
        sample_gate = 1'b0;
        repeat (12) @(negedge clk);
        chk_seq("t1_c1", base, 1, 8);
        gate_run(8);
        chk_seq("t1_c12", base, 1, 16);
        chk("t1_chirp", {16'd0, chirp_cnt}, 32'd2);
        base = q.size();
        gate_run(8);
        chk("t1_sat_out", 32'(q.size() - base), 32'd0);
        chk("t1_sat_under", underrun_cnt, 32'd0);
        chk("t1_sat_chirp", {16'd0, chirp_cnt}, 32'd2);
        CPIE = 1'b1;
        @(negedge clk);
        CPIE = 1'b0;
        @(negedge clk);
        chk("t1_cpie_hold", {16'd0, chirp_cnt}, 32'd2);

        // short packet and orphan run
        do_reset();
        cpib(8, 4);
        ib = irp_total;
        send_pkt(1, 7);
        repeat (2) @(negedge clk);
        chk("t2_ferr_short", frame_err_cnt, 32'd1);
        chk("t2_irp_short", 32'(irp_total - ib), 32'd1);
        for (int i = 0; i < 3; i++) put(w(50 + i), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t2_ferr_orphan", frame_err_cnt, 32'd2);
        chk("t2_irp_orphan", 32'(irp_total - ib), 32'd2);

        // underrun: level 3 below sample_num 8
        do_reset();
        cpib(8, 4);
        for (int i = 0; i < 3; i++) put(w(1 + i), i == 0, 1'b0);
        @(negedge clk);
        ib = irp_total;
        base = q.size();
        gate_run(8);
        chk_seq("t3_zero", base, 0, 8);
        chk("t3_under", underrun_cnt, 32'd1);
        chk("t3_irp", 32'(irp_total - ib), 32'd1);
        chk("t3_chirp", {16'd0, chirp_cnt}, 32'd1);
        chk("t3_ferr", frame_err_cnt, 32'd0);

        // early gate fall keeps the next chirp aligned
        do_reset();
        cpib(8, 4);
        send_pkt(1, 8);
        send_pkt(9, 8);
        base = q.size();
        gate_run(4);
        chk_seq("t4_part", base, 1, 4);
        base = q.size();
        gate_run(8);
        chk_seq("t4_next", base, 9, 8);
        chk("t4_chirp", {16'd0, chirp_cnt}, 32'd2);

        // full FIFO backpressure released by one pop
        do_reset();
        cpib(8, 4);
        send_pkt(1, 8);
        send_pkt(9, 8);
        chk("t5_full_ready", {31'd0, s_ready}, 32'd0);
        base = q.size();
        sample_gate = 1'b1;
        s_data = w(17);
        s_sop = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        chk("t5_ready_after_pop", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_sop = 1'b0;
        for (int i = 18; i <= 24; i++) put(w(i), 1'b0, i == 24);
        sample_gate = 1'b0;
        repeat (12) @(negedge clk);
        gate_run(8);
        gate_run(8);
        chk_seq("t5_noloss", base, 1, 24);
        chk("t5_ferr", frame_err_cnt, 32'd0);

        // reset in the middle of a chirp
        do_reset();
        cpib(4, 4);
        send_pkt(1, 4);
        send_pkt(5, 4);
        send_pkt(9, 4);
        gate_run(4);
        chk("t6_chirp_pre", {16'd0, chirp_cnt}, 32'd1);
        sample_gate = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_mid_valid", {31'd0, adc_data_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", {31'd0, adc_data_valid}, 32'd0);
        chk("t6_rst_data", {adc_data_chb, adc_data_cha}, 32'd0);
        chk("t6_rst_chirp", {16'd0, chirp_cnt}, 32'd0);
        chk("t6_rst_ready", {31'd0, s_ready}, 32'd0);
        sample_gate = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        cpib(4, 4);
        base = q.size();
        gate_run(4);
        chk("t6_flushed_under", underrun_cnt, 32'd1);
        chk_seq("t6_zero", base, 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
